// File: rtl/cdb_pkg.sv
// Shared widths, the empty-tag value and the result record for the common data bus.
package cdb_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned TAG_W_DEF  = 4;
    localparam int unsigned REG_W_DEF  = 4;

    localparam logic [3:0] TAG_NONE = 4'hF;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        logic [TAG_W_DEF-1:0]  src;
        logic [REG_W_DEF-1:0]  regIdx;
        logic                  nowb;
    } cdb_result_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant among candidates, search starts after the last winner.
module rr_arbiter #(
    parameter int unsigned NREQ = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] candidates,
    output logic [NREQ-1:0] grant
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IDX_W-1:0] lastGrant;
    logic [IDX_W-1:0] winIdx;
    logic             found;
    int unsigned      idx;

    always_comb begin
        grant  = '0;
        winIdx = lastGrant;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(lastGrant) + k) % NREQ;
            if (!found && candidates[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                winIdx     = IDX_W'(idx);
            end
        end
    end

    // Idle cycles keep the previous winner so fairness survives gaps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lastGrant <= IDX_W'(NREQ - 1);
        else if (found)
            lastGrant <= winIdx;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Merges NREQ result producers onto one registered common data bus, round-robin.
// CDB_SKID_EN adds a holding register per requester so req_ready never depends on req_valid.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int unsigned NREQ   = 2,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned TAG_W  = TAG_W_DEF,
    parameter int unsigned REG_W  = REG_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*DATA_W-1:0] req_data,
    input  logic [NREQ*TAG_W-1:0]  req_src,
    input  logic [NREQ*REG_W-1:0]  req_reg,
    input  logic [NREQ-1:0]        req_nowb,
    output logic                 cdb_valid,
    output logic [DATA_W-1:0]    cdb_data,
    output logic [TAG_W-1:0]     cdb_src,
    output logic [REG_W-1:0]     cdb_reg,
    output logic                 cdb_nowb,
    output logic [NREQ-1:0]      cdb_grant,
    output logic [15:0]          conflict_count
);

    logic [NREQ-1:0]   cand;
    logic [NREQ-1:0]   grant;
    logic [DATA_W-1:0] entData [NREQ];
    logic [TAG_W-1:0]  entSrc  [NREQ];
    logic [REG_W-1:0]  entReg  [NREQ];
    logic [NREQ-1:0]   entNowb;
    logic [DATA_W-1:0] selData;
    logic [TAG_W-1:0]  selSrc;
    logic [REG_W-1:0]  selReg;
    logic              selNowb;

    rr_arbiter #(.NREQ(NREQ)) uArb (
        .clk        (clk),
        .rst        (rst),
        .candidates (cand),
        .grant      (grant)
    );

`ifdef CDB_SKID_EN
    logic [NREQ-1:0] holdFull;
    logic [NREQ-1:0] accept;

    // A slot being broadcast this cycle can be refilled in the same cycle.
    assign cand      = holdFull;
    assign req_ready = ~holdFull | grant;
    assign accept    = req_valid & req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            holdFull <= '0;
            entNowb  <= '0;
            for (int unsigned i = 0; i < NREQ; i++) begin
                entData[i] <= '0;
                entSrc[i]  <= '0;
                entReg[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (accept[i]) begin
                    holdFull[i] <= 1'b1;
                    entData[i]  <= req_data[i*DATA_W +: DATA_W];
                    entSrc[i]   <= req_src[i*TAG_W +: TAG_W];
                    entReg[i]   <= req_reg[i*REG_W +: REG_W];
                    entNowb[i]  <= req_nowb[i];
                end else if (grant[i]) begin
                    holdFull[i] <= 1'b0;
                end
            end
        end
    end
`else
    assign cand      = req_valid;
    assign req_ready = grant;
    assign entNowb   = req_nowb;

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            entData[i] = req_data[i*DATA_W +: DATA_W];
            entSrc[i]  = req_src[i*TAG_W +: TAG_W];
            entReg[i]  = req_reg[i*REG_W +: REG_W];
        end
    end
`endif

    always_comb begin
        selData = '0;
        selSrc  = '0;
        selReg  = '0;
        selNowb = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                selData = entData[i];
                selSrc  = entSrc[i];
                selReg  = entReg[i];
                selNowb = entNowb[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cdb_valid      <= 1'b0;
            cdb_data       <= '0;
            cdb_src        <= TAG_W'(TAG_NONE);
            cdb_reg        <= '0;
            cdb_nowb       <= 1'b0;
            cdb_grant      <= '0;
            conflict_count <= '0;
        end else begin
            cdb_valid <= |grant;
            cdb_grant <= grant;
            if (|grant) begin
                cdb_data <= selData;
                cdb_src  <= selSrc;
                cdb_reg  <= selReg;
                cdb_nowb <= selNowb;
            end
            if ($countones(cand) > 1 && conflict_count != '1)
                conflict_count <= conflict_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter in its default build (combinational ready, 1-cycle latency).
module tb_cdb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_data;
    logic [7:0]  req_src;
    logic [7:0]  req_reg;
    logic [1:0]  req_nowb;
    logic        cdb_valid;
    logic [15:0] cdb_data;
    logic [3:0]  cdb_src;
    logic [3:0]  cdb_reg;
    logic        cdb_nowb;
    logic [1:0]  cdb_grant;
    logic [15:0] conflict_count;

    int unsigned tests  = 0;
    int unsigned failed = 0;

    always #5 clk = ~clk;

    cdb_arbiter #(.NREQ(2), .DATA_W(16), .TAG_W(4), .REG_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_data       (req_data),
        .req_src        (req_src),
        .req_reg        (req_reg),
        .req_nowb       (req_nowb),
        .cdb_valid      (cdb_valid),
        .cdb_data       (cdb_data),
        .cdb_src        (cdb_src),
        .cdb_reg        (cdb_reg),
        .cdb_nowb       (cdb_nowb),
        .cdb_grant      (cdb_grant),
        .conflict_count (conflict_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [15:0] d0, input logic [15:0] d1,
                         input logic [3:0] s0, input logic [3:0] s1,
                         input logic [3:0] r0, input logic [3:0] r1, input logic [1:0] nb);
        req_valid = v;
        req_data  = {d1, d0};
        req_src   = {s1, s0};
        req_reg   = {r1, r0};
        req_nowb  = nb;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] fData, lData;
    logic        expWin;
    logic [15:0] expCnt;

    initial begin
        rst = 1'b1;
        drive(2'b00, 16'h0, 16'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2'b00);
        #12;
        check("rst_valid", 32'(cdb_valid), 32'd0);
        check("rst_data", 32'(cdb_data), 32'h0);
        check("rst_src", 32'(cdb_src), 32'hF);
        check("rst_reg", 32'(cdb_reg), 32'h0);
        check("rst_nowb", 32'(cdb_nowb), 32'd0);
        check("rst_grant", 32'(cdb_grant), 32'd0);
        check("rst_count", 32'(conflict_count), 32'd0);
        tick();
        rst = 1'b0;

        // Single requester (load unit)
        drive(2'b10, 16'h0, 16'h0042, 4'h0, 4'h2, 4'h0, 4'h5, 2'b00);
        #1;
        check("single_ready", 32'(req_ready), 32'b10);
        tick();
        check("single_valid", 32'(cdb_valid), 32'd1);
        check("single_data", 32'(cdb_data), 32'h0042);
        check("single_src", 32'(cdb_src), 32'h2);
        check("single_reg", 32'(cdb_reg), 32'h5);
        check("single_grant", 32'(cdb_grant), 32'b10);
        check("single_count", 32'(conflict_count), 32'd0);
        drive(2'b00, 16'h0, 16'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2'b00);
        tick();
        check("idle_valid", 32'(cdb_valid), 32'd0);
        check("idle_grant", 32'(cdb_grant), 32'd0);
        check("idle_data_hold", 32'(cdb_data), 32'h0042);

        // Two-way contest: float wins, load follows next cycle
        drive(2'b11, 16'h0003, 16'h0007, 4'h0, 4'h3, 4'h1, 4'h2, 2'b00);
        #1;
        check("pair_ready0", 32'(req_ready), 32'b01);
        tick();
        check("pair_grant0", 32'(cdb_grant), 32'b01);
        check("pair_data0", 32'(cdb_data), 32'h0003);
        check("pair_src0", 32'(cdb_src), 32'h0);
        check("pair_count0", 32'(conflict_count), 32'd1);
        drive(2'b10, 16'h0003, 16'h0007, 4'h0, 4'h3, 4'h1, 4'h2, 2'b00);
        #1;
        check("pair_ready1", 32'(req_ready), 32'b10);
        tick();
        check("pair_grant1", 32'(cdb_grant), 32'b10);
        check("pair_data1", 32'(cdb_data), 32'h0007);
        check("pair_src1", 32'(cdb_src), 32'h3);
        check("pair_reg1", 32'(cdb_reg), 32'h2);
        check("pair_count1", 32'(conflict_count), 32'd1);

        // Continuous contention, each producer advances its payload once accepted
        fData  = 16'h0100;
        lData  = 16'h0200;
        expWin = 1'b0;
        expCnt = 16'd1;
        for (int k = 0; k < 6; k++) begin
            drive(2'b11, fData, lData, 4'h1, 4'h4, 4'h6, 4'h7, 2'b00);
            #1;
            check("cont_ready", 32'(req_ready), expWin ? 32'b10 : 32'b01);
            tick();
            expCnt = expCnt + 16'd1;
            check("cont_grant", 32'(cdb_grant), expWin ? 32'b10 : 32'b01);
            check("cont_data", 32'(cdb_data), expWin ? 32'(lData) : 32'(fData));
            check("cont_count", 32'(conflict_count), 32'(expCnt));
            if (expWin) lData = lData + 16'd1;
            else        fData = fData + 16'd1;
            expWin = ~expWin;
        end

        // jeq outcome: broadcast without register write
        drive(2'b01, 16'hFFFE, 16'h0, 4'h6, 4'h0, 4'h0, 4'h0, 2'b01);
        tick();
        check("jeq_valid", 32'(cdb_valid), 32'd1);
        check("jeq_nowb", 32'(cdb_nowb), 32'd1);
        check("jeq_data", 32'(cdb_data), 32'hFFFE);
        check("jeq_count", 32'(conflict_count), 32'd7);

        // Asynchronous reset mid-cycle with both pending; last winner was float
        drive(2'b11, 16'h0003, 16'h0007, 4'h0, 4'h3, 4'h1, 4'h2, 2'b00);
        #1;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(cdb_valid), 32'd0);
        check("arst_data", 32'(cdb_data), 32'h0);
        check("arst_src", 32'(cdb_src), 32'hF);
        check("arst_nowb", 32'(cdb_nowb), 32'd0);
        check("arst_count", 32'(conflict_count), 32'd0);
        rst = 1'b0;
        #1;
        check("arst_ready", 32'(req_ready), 32'b01);
        tick();
        check("arst_grant", 32'(cdb_grant), 32'b01);
        check("arst_data1", 32'(cdb_data), 32'h0003);
        check("arst_count1", 32'(conflict_count), 32'd1);

        // Saturation under constant contention
        for (int i = 0; i < 65533; i++) @(posedge clk);
        #1;
        check("sat_fffe", 32'(conflict_count), 32'hFFFE);
        tick();
        check("sat_ffff", 32'(conflict_count), 32'hFFFF);
        for (int i = 0; i < 4466; i++) @(posedge clk);
        #1;
        check("sat_hold", 32'(conflict_count), 32'hFFFF);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
